// File: rtl/sudoku_pkg.sv
// Shared definitions for the 4x4 Sudoku board checker.
//   VAL_W            : cell value width (0 = empty, 1..4 digits, 5..7 illegal)
//   NUM_GROUPS       : constraint groups scanned (4 rows, 4 columns, 4 boxes)
//   CELLS_PER_GROUP  : cells read per group
//   NO_BAD_GROUP     : first_bad_group value when no group failed
//   ROW_G0/COL_G0/BOX_G0 : first group index of each group kind
//   state_t          : checker sequencer states
package sudoku_pkg;

    localparam int unsigned VAL_W           = 3;
    localparam int unsigned NUM_GROUPS      = 12;
    localparam int unsigned CELLS_PER_GROUP = 4;

    localparam logic [3:0] NO_BAD_GROUP = 4'hF;
    localparam logic [3:0] ROW_G0       = 4'd0;
    localparam logic [3:0] COL_G0       = 4'd4;
    localparam logic [3:0] BOX_G0       = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sudoku_group_addr.sv
// Combinational cell-address generator for one constraint group.
//   g    : group index (0..3 rows, 4..7 columns, 8..11 boxes)
//   k    : cell index within the group (0..3)
//   addr : board address = row*4 + col; 0 for out-of-range groups
module sudoku_group_addr
    import sudoku_pkg::*;
(
    input  logic [3:0] g,
    input  logic [1:0] k,
    output logic [3:0] addr
);

    // Group bases are multiples of 4, so g[1:0] is already the row,
    // column or box number within each kind.
    always_comb begin
        addr = '0;
        if (g < COL_G0) begin
            addr = {g[1:0], k};
        end else if (g < BOX_G0) begin
            addr = {k, g[1:0]};
        end else if (g < BOX_G0 + 4'd4) begin
            // row = 2*b[1] + k[1], col = 2*b[0] + k[0]
            addr = {g[1], k[1], g[0], k[0]};
        end
    end

endmodule

// File: rtl/board_check_seq.sv
// Board solution checker: walks all 12 Sudoku constraint groups over the
// board read port and reports fill/conflict status.
//   clka            : clock, all logic on posedge
//   restart_n       : synchronous active-low reset
//   start           : request a check (accepted only when idle)
//   rd_en/rd_addr   : board read strobe and cell address
//   rd_data         : cell value, valid one cycle after rd_en
//   busy            : scan in progress (through the done cycle)
//   done            : one-cycle completion pulse
//   solved          : filled & ~conflict, updated after done
//   filled          : no empty cell seen
//   conflict        : duplicate or illegal value seen
//   first_bad_group : lowest failing group, 4'hF if none
module board_check_seq
    import sudoku_pkg::*;
#(
    parameter int unsigned VAL_W      = sudoku_pkg::VAL_W,
    parameter int unsigned NUM_GROUPS = sudoku_pkg::NUM_GROUPS
) (
    input  logic             clka,
    input  logic             restart_n,
    input  logic             start,
    output logic             rd_en,
    output logic [3:0]       rd_addr,
    input  logic [VAL_W-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             solved,
    output logic             filled,
    output logic             conflict,
    output logic [3:0]       first_bad_group
);

    localparam logic [3:0] LAST_GROUP = 4'(NUM_GROUPS - 1);
    localparam logic [1:0] LAST_CELL  = 2'(CELLS_PER_GROUP - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] g;
    logic [1:0] k;
    logic [3:0] seen;
    logic       cap_pend;
    logic [3:0] grp_addr;

    logic       val_empty;
    logic       val_legal;
    logic [1:0] val_idx;
    logic [3:0] val_bit;
    logic       val_conflict;

    sudoku_group_addr u_group_addr (
        .g    (g),
        .k    (k),
        .addr (grp_addr)
    );

    // State register
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_READ;
            ST_READ: if (k == LAST_CELL) state_nxt = ST_EVAL;
            ST_EVAL: state_nxt = (g == LAST_GROUP) ? ST_DONE : ST_READ;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_en   = (state == ST_READ);
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        rd_addr = (state == ST_READ) ? grp_addr : '0;
    end

    // Classification of the value returned for the previous read.
    // Digit 4 (3'b100) maps to index 3 through the 2-bit wrap of 0-1.
    always_comb begin
        val_empty    = (rd_data == '0);
        val_legal    = !val_empty && (rd_data <= VAL_W'(CELLS_PER_GROUP));
        val_idx      = rd_data[1:0] - 2'd1;
        val_bit      = val_legal ? (4'b0001 << val_idx) : '0;
        val_conflict = val_legal ? seen[val_idx] : !val_empty;
    end

    // Counters, seen mask and result flags
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            g               <= '0;
            k               <= '0;
            seen            <= '0;
            cap_pend        <= 1'b0;
            filled          <= 1'b0;
            conflict        <= 1'b0;
            solved          <= 1'b0;
            first_bad_group <= NO_BAD_GROUP;
        end else begin
            // rd_data answers the read strobe of the previous cycle
            cap_pend <= (state == ST_READ);

            if (cap_pend) begin
                if (val_empty) filled <= 1'b0;
                if (val_conflict) begin
                    conflict <= 1'b1;
                    if (!conflict) first_bad_group <= g;
                end
                seen <= seen | val_bit;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        seen            <= '0;
                        filled          <= 1'b1;
                        conflict        <= 1'b0;
                        first_bad_group <= NO_BAD_GROUP;
                        solved          <= 1'b0;
                        g               <= '0;
                        k               <= '0;
                    end
                end
                ST_READ: begin
                    k <= k + 2'd1;
                end
                ST_EVAL: begin
                    // overrides the capture update above: last cell of
                    // the group has already been checked against seen
                    seen <= '0;
                    k    <= '0;
                    if (g != LAST_GROUP) g <= g + 4'd1;
                end
                ST_DONE: begin
                    solved <= filled & ~conflict;
                    g      <= '0;
                    k      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_check_seq.sv
module tb_board_check_seq;

    logic       clka;
    logic       restart_n;
    logic       start;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [2:0] rd_data;
    logic       busy;
    logic       done;
    logic       solved;
    logic       filled;
    logic       conflict;
    logic [3:0] first_bad_group;

    board_check_seq #(.VAL_W(3), .NUM_GROUPS(12)) dut (
        .clka            (clka),
        .restart_n       (restart_n),
        .start           (start),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .solved          (solved),
        .filled          (filled),
        .conflict        (conflict),
        .first_bad_group (first_bad_group)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    // board storage model: one-cycle read latency
    logic [2:0] board [16];
    always @(posedge clka) if (rd_en) rd_data <= board[rd_addr];

    typedef struct {
        int         done_cyc;
        logic       filled;
        logic       conflict;
        logic       solved;
        logic [3:0] fbg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   nreads = 0;
    logic [3:0] addr_log [64];
    logic sol_pend = 1'b0;
    logic sol_exp  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT signals completion
    always @(negedge clka) begin
        exp_t e;
        if (!restart_n) begin
            nreads   = 0;
            sol_pend = 1'b0;
        end else begin
            if (sol_pend) begin
                check("solved", {31'd0, solved}, {31'd0, sol_exp});
                check("busy_after_done", {31'd0, busy}, 32'd0);
                sol_pend = 1'b0;
            end
            if (rd_en) begin
                if (nreads < 64) addr_log[nreads] = rd_addr;
                nreads++;
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("read_count", nreads, 48);
                    check("filled", {31'd0, filled}, {31'd0, e.filled});
                    check("conflict", {31'd0, conflict}, {31'd0, e.conflict});
                    check("first_bad_group", {28'd0, first_bad_group}, {28'd0, e.fbg});
                    check("box1_addrs", {16'd0, addr_log[36], addr_log[37], addr_log[38], addr_log[39]},
                          32'h2367);
                    sol_pend = 1'b1;
                    sol_exp  = e.solved;
                end
                nreads = 0;
            end
        end
    end

    task automatic load_board(input int r0, input int r1, input int r2, input int r3);
        int rows[4];
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        for (int r = 0; r < 4; r++) begin
            board[r*4+0] = 3'((rows[r] / 1000) % 10);
            board[r*4+1] = 3'((rows[r] / 100) % 10);
            board[r*4+2] = 3'((rows[r] / 10) % 10);
            board[r*4+3] = 3'(rows[r] % 10);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #2;
    endtask

    task automatic issue_start(input logic f, input logic c, input logic [3:0] fbg);
        exp_t e;
        tick();
        start = 1'b1;
        e.done_cyc = cyc + 61;
        e.filled   = f;
        e.conflict = c;
        e.solved   = f & ~c;
        e.fbg      = fbg;
        q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (q.size() == 0 && !sol_pend) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("scan_timeout", 32'd1, 32'd0);
            q.delete();
        end
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clka);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({tag, "_rd_addr"}, {28'd0, rd_addr}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_flags"}, {29'd0, solved, filled, conflict}, 32'd0);
        check({tag, "_fbg"}, {28'd0, first_bad_group}, 32'hF);
    endtask

    initial begin
        restart_n = 1'b0;
        start     = 1'b0;
        load_board(1234, 3412, 2143, 4321);
        repeat (3) tick();
        check_reset_state("reset");
        tick();
        restart_n = 1'b1;
        repeat (2) tick();

        // valid solution
        issue_start(1'b1, 1'b0, 4'hF);
        wait_idle();

        // cell (3,3) empty
        load_board(1234, 3412, 2143, 4320);
        issue_start(1'b0, 1'b0, 4'hF);
        wait_idle();

        // row 0 swapped: column 0 duplicates first
        load_board(2134, 3412, 2143, 4321);
        issue_start(1'b1, 1'b1, 4'd4);
        wait_idle();

        // illegal value in row 1
        load_board(1234, 3452, 2143, 4321);
        issue_start(1'b1, 1'b1, 4'd1);
        wait_idle();

        // start re-pulsed mid-scan must be ignored
        load_board(1234, 3412, 2143, 4321);
        issue_start(1'b1, 1'b0, 4'hF);
        repeat (19) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // reset mid-scan: abort, no done pulse
        issue_start(1'b1, 1'b0, 4'hF);
        repeat (29) tick();
        restart_n = 1'b0;
        q.delete();
        tick();
        restart_n = 1'b1;
        check_reset_state("abort");
        repeat (70) tick();
        check("abort_queue_empty", q.size(), 32'd0);

        // full scan after the abort
        issue_start(1'b1, 1'b0, 4'hF);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_check_seq.md
Name: board_check_seq

Overview:
- Sequences the 4x4 Sudoku solution check over the board storage read port after the main FSM enters the checking phase.
- Walks all 12 constraint groups (4 rows, 4 columns, 4 2x2 boxes) and reads 4 cells per group.
- Reports filled, conflict, solved and the index of the first failing group.
- Sits between the main FSM (start from check_flag, solved back to the FSM's solved input) and the board register file.

Parameters:
- VAL_W, 3, cell value width. 0 = empty, 1..4 = legal digits, 5..7 = illegal.
- NUM_GROUPS, 12, number of constraint groups. Fixed for 4x4.

Ports:
- clka  in  1  single clock, all logic on posedge.
- restart_n  in  1  synchronous, active-low reset.
- start  in  1  request a full board check. Sampled only in IDLE.
- rd_en  out  1  board read strobe.
- rd_addr  out  4  cell address = row*4+col.
- rd_data  in  VAL_W  cell value, valid exactly 1 cycle after rd_en.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the check completes.
- solved  out  1  filled & ~conflict; held until the next accepted start.
- filled  out  1  no empty cell seen.
- conflict  out  1  a duplicate or illegal value was seen.
- first_bad_group  out  4  lowest group index with a conflict; 4'hF if none.

Behaviour:
- Reset (restart_n=0 at a clka edge): state IDLE; rd_en=0, rd_addr=0, busy=0, done=0, solved=0, filled=0, conflict=0, first_bad_group=4'hF, group/cell counters=0.
- States: IDLE, READ, EVAL, DONE.
- IDLE, start=1: clear seen mask, set filled=1, conflict=0, first_bad_group=F, solved=0; go to READ with g=0, k=0.
- READ: rd_en=1, rd_addr=addr(g,k). Capture rd_data of the previous k when k>0. k++. After k=3, go to EVAL.
- EVAL: rd_en=0. Capture k=3 data and finish the group evaluation. Clear seen mask. If g=11 go to DONE, else g++, k=0, go to READ.
- DONE: done=1 for one cycle; solved<=filled&~conflict; busy=0 next cycle; go to IDLE.
- Timing: start high in cycle 0 gives 5 cycles per group, so cycles 1..60 scan and done=1 in cycle 61. No early exit; latency is constant.
- Per captured value v:
  - v=0: filled<=0.
  - v in 1..4: if seen[v-1] is already set, conflict<=1; then set seen[v-1].
  - v>=5: conflict<=1.
  - On the first conflict, first_bad_group<=g. It is never overwritten later in the same scan.
- Address map:
  - g=0..3 (row r=g): addr=r*4+k.
  - g=4..7 (column c=g-4): addr=k*4+c.
  - g=8..11 (box b=g-8): row=2*(b>>1)+(k>>1), col=2*(b&1)+(k&1).
- start while busy: ignored, with no effect on the counters.
- Reset mid-scan: abort immediately to the reset values; no done pulse.
- Outputs are stable between done and the next accepted start.

Decomposition:
- Shared package sudoku_pkg:
  - State encodings (IDLE..DONE).
  - VAL_W, NUM_GROUPS, CELLS_PER_GROUP=4.
  - NO_BAD_GROUP=4'hF.
  - Group base constants ROW_G0=0, COL_G0=4, BOX_G0=8.
- Sub-module sudoku_group_addr: purely combinational (g[3:0], k[1:0]) -> addr[3:0].

Test Plan:
- Board rows 1234/3412/2143/4321, start pulse -> 48 reads, done in cycle 61, solved=1, filled=1, conflict=0, first_bad_group=F.
- Same board with cell(3,3)=0 -> solved=0, filled=0, conflict=0, first_bad_group=F.
- Swap cells (0,0),(0,1) (row0=2134) -> rows pass, column 0 = 2,3,2,4 -> conflict=1, first_bad_group=4, solved=0.
- Cell(1,2)=5 -> conflict=1, first_bad_group=1.
- Check the rd_addr sequence for g=9 (box 1): 2,3,6,7.
- start re-pulsed in cycle 20 -> ignored, done still in cycle 61.
- restart_n low in cycle 30 -> IDLE next cycle, busy=0, no done.
- New start -> full 61-cycle scan with correct results.
